// File: rtl/board_shuffler_pkg.sv
// board_shuffler_pkg: shared game types, board constants and blank-ring helpers
package board_shuffler_pkg;
  typedef enum logic [1:0] {CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED} game_status_t;
  typedef enum logic [1:0] {LEFT_UP = 2'b00, RIGHT_UP = 2'b01, LEFT_DOWN = 2'b10, RIGHT_DOWN = 2'b11} pos_t;
  typedef enum logic [2:0] {IDLE, LOAD, SHUFFLE, HOME, CHECK, LAP, DONE} shuf_state_t;
  localparam logic [2:0] BLANK = 3'b100;
  localparam logic [11:0] SOLVED_LD = 12'b000_001_100_011;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int LU_OFS = 9;
  localparam int RU_OFS = 6;
  localparam int LD_OFS = 3;
  localparam int RD_OFS = 0;
  function automatic logic [3:0] slot_ofs(input pos_t p);
    return p == LEFT_UP ? 4'(LU_OFS) : p == RIGHT_UP ? 4'(RU_OFS) : p == LEFT_DOWN ? 4'(LD_OFS) : 4'(RD_OFS);
  endfunction
  // clockwise ring: LU -> RU -> RD -> LD -> LU
  function automatic pos_t cw_next(input pos_t p);
    return p == LEFT_UP ? RIGHT_UP : p == RIGHT_UP ? RIGHT_DOWN : p == RIGHT_DOWN ? LEFT_DOWN : LEFT_UP;
  endfunction
  function automatic pos_t ccw_next(input pos_t p);
    return p == LEFT_UP ? LEFT_DOWN : p == LEFT_DOWN ? RIGHT_DOWN : p == RIGHT_DOWN ? RIGHT_UP : LEFT_UP;
  endfunction
endpackage

// File: rtl/board_shuffler_blank_mover.sv
// board_shuffler_blank_mover: one blank move (swap blank slot with its CW/CCW neighbour)
// board in, blank position in, cw (1 = clockwise) in; next_board, next_blank out
module board_shuffler_blank_mover
  import board_shuffler_pkg::*;
(
  input  logic [11:0] board,
  input  pos_t        blank,
  input  logic        cw,
  output logic [11:0] next_board,
  output pos_t        next_blank
);
  logic [3:0] src_ofs, dst_ofs;
  always_comb begin
    next_blank = cw ? cw_next(blank) : ccw_next(blank);
    src_ofs = slot_ofs(next_blank);
    dst_ofs = slot_ofs(blank);
    next_board = board;
    next_board[dst_ofs +: 3] = board[src_ofs +: 3];
    next_board[src_ofs +: 3] = BLANK;
  end
endmodule

// File: rtl/board_shuffler.sv
// board_shuffler: scrambles the solved board by random legal blank moves, delivers it with blank at LEFT_DOWN
// clk_d/reset (async, active high); start requests a board (IDLE only);
// origin_board {LU,RU,LD,RD}, board_valid one-cycle pulse, busy high outside IDLE
module board_shuffler
  import board_shuffler_pkg::*;
#(
  parameter int          SHUFFLE_STEPS = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_d,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] origin_board,
  output logic        board_valid,
  output logic        busy
);
  localparam logic [7:0] LAST = 8'(SHUFFLE_STEPS - 1);
  shuf_state_t state;
  logic [15:0] lfsr;
  logic [11:0] work, nb;
  pos_t blank, nblank;
  logic [7:0] cnt;
  logic mv_cw;
  // only SHUFFLE picks a random direction; HOME and LAP always walk clockwise
  assign mv_cw = (state == SHUFFLE) ? lfsr[0] : 1'b1;
  board_shuffler_blank_mover mover (
    .board(work),
    .blank(blank),
    .cw(mv_cw),
    .next_board(nb),
    .next_blank(nblank)
  );
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lfsr <= SEED;
      work <= SOLVED_LD;
      blank <= LEFT_DOWN;
      cnt <= '0;
      origin_board <= SOLVED_LD;
      board_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      // free-running so the shuffle depends on when start arrives
      lfsr <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
      board_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
        end
        LOAD: begin
          work <= SOLVED_LD;
          blank <= LEFT_DOWN;
          cnt <= '0;
          state <= (SHUFFLE_STEPS == 0) ? CHECK : SHUFFLE;
        end
        SHUFFLE: begin
          work <= nb;
          blank <= nblank;
          cnt <= cnt + 8'd1;
          if (cnt == LAST) state <= (nblank == LEFT_DOWN) ? CHECK : HOME;
        end
        HOME: begin
          work <= nb;
          blank <= nblank;
          if (nblank == LEFT_DOWN) state <= CHECK;
        end
        CHECK: begin
          cnt <= '0;
          state <= (work == SOLVED_LD) ? LAP : DONE;
        end
        // a full lap from LEFT_DOWN rotates the three tiles, leaving an unsolved board
        LAP: begin
          work <= nb;
          blank <= nblank;
          cnt <= cnt + 8'd1;
          if (cnt == 8'd3) state <= DONE;
        end
        DONE: begin
          origin_board <= work;
          board_valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_shuffler.sv
// tb_board_shuffler: randomized self-checking bench with a tile-ring reference model
module tb_board_shuffler;
  localparam logic [11:0] SOLVED = 12'b000_001_100_011;
  localparam logic [11:0] LAPPED = 12'b001_011_100_000;
  logic clk_d = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [11:0] board, board0, board1;
  logic valid, valid0, valid1, busy, busy0, busy1;
  logic [15:0] ml;
  int checks = 0;
  int errors = 0;

  board_shuffler dut (.clk_d(clk_d), .reset(reset), .start(start), .origin_board(board), .board_valid(valid), .busy(busy));
  board_shuffler #(.SHUFFLE_STEPS(0)) dut0 (.clk_d(clk_d), .reset(reset), .start(start), .origin_board(board0), .board_valid(valid0), .busy(busy0));
  board_shuffler #(.SHUFFLE_STEPS(1)) dut1 (.clk_d(clk_d), .reset(reset), .start(start), .origin_board(board1), .board_valid(valid1), .busy(busy1));

  always #5 clk_d = ~clk_d;

  function automatic logic [15:0] nxt(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction

  always @(posedge clk_d or posedge reset) ml <= reset ? 16'hACE1 : nxt(ml);

  // tiles kept in clockwise ring order LU, RU, RD, LD; blank starts at ring index 3 (LD)
  function automatic void model(input logic [15:0] m, input int steps, output logic [11:0] brd, output int lat);
    logic [2:0] t [4];
    logic [15:0] v;
    int r, n, h, l;
    t = '{3'b000, 3'b001, 3'b011, 3'b100};
    r = 3;
    h = 0;
    l = 0;
    v = nxt(nxt(m));
    for (int i = 0; i < steps; i++) begin
      n = v[0] ? (r + 1) % 4 : (r + 3) % 4;
      t[r] = t[n]; t[n] = 3'b100; r = n;
      v = nxt(v);
    end
    while (r != 3) begin
      n = (r + 1) % 4;
      t[r] = t[n]; t[n] = 3'b100; r = n;
      h++;
    end
    if ({t[0], t[1], t[3], t[2]} == SOLVED) begin
      l = 1;
      for (int i = 0; i < 4; i++) begin
        n = (r + 1) % 4;
        t[r] = t[n]; t[n] = 3'b100; r = n;
      end
    end
    brd = {t[0], t[1], t[3], t[2]};
    lat = steps + 3 + h + 4 * l;
  endfunction

  // lat = edges after the start-sampling edge until board_valid is seen, -1 on timeout
  task automatic wait_valid(input int which, input bit drop, output int lat);
    lat = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_d);
      if (drop) start = 1'b0;
      if ((which == 0) ? valid0 : (which == 1) ? valid1 : valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle_all;
    for (int c = 0; c < 100; c++) begin
      if (!busy && !busy0 && !busy1) break;
      @(negedge clk_d);
    end
    checks++;
    if (busy || busy0 || busy1) begin
      errors++;
      $display("FAIL idle_wait: busy=%b%b%b required 000", busy, busy0, busy1);
    end
  endtask

  task automatic test_reset;
    #12;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (board !== SOLVED) begin errors++; $display("FAIL reset_board: got %b want %b", board, SOLVED); end
    @(negedge clk_d);
    reset = 1'b0;
    repeat (3) @(negedge clk_d);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b want 0", busy); end
  endtask

  task automatic test_zero_steps;
    int lat;
    idle_all();
    start = 1'b1;
    wait_valid(0, 1'b1, lat);
    checks += 2;
    if (lat !== 7) begin errors++; $display("FAIL zero_latency: got %0d want 7", lat); end
    if (board0 !== LAPPED) begin errors++; $display("FAIL zero_board: got %b want %b", board0, LAPPED); end
    @(negedge clk_d);
    checks++;
    if (valid0 !== 1'b0) begin errors++; $display("FAIL zero_pulse: valid still %b want 0", valid0); end
  endtask

  task automatic test_one_step(input bit cw);
    int lat;
    logic [15:0] v;
    idle_all();
    for (int c = 0; c < 200; c++) begin
      v = nxt(nxt(ml));
      if (v[0] == cw) break;
      @(negedge clk_d);
    end
    start = 1'b1;
    wait_valid(1, 1'b1, lat);
    checks += 2;
    if (lat !== (cw ? 7 : 9)) begin errors++; $display("FAIL one_step_latency cw=%0b: got %0d want %0d", cw, lat, cw ? 7 : 9); end
    if (board1 !== LAPPED) begin errors++; $display("FAIL one_step_board cw=%0b: got %b want %b", cw, board1, LAPPED); end
  endtask

  task automatic test_random(input int n);
    int lat, elat;
    logic [11:0] eb;
    logic [7:0] seen;
    idle_all();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk_d);
      start = 1'b1;
      model(ml, 16, eb, elat);
      wait_valid(2, 1'b1, lat);
      seen = '0;
      for (int s = 0; s < 4; s++) seen[board[3*s +: 3]] = 1'b1;
      checks += 6;
      if (lat !== elat) begin errors++; $display("FAIL rand_latency #%0d: got %0d want %0d", i, lat, elat); end
      if (board !== eb) begin errors++; $display("FAIL rand_board #%0d: got %b want %b", i, board, eb); end
      if (board[5:3] !== 3'b100) begin errors++; $display("FAIL rand_blank_ld #%0d: got %b want 100", i, board[5:3]); end
      if (seen !== 8'b0001_1011) begin errors++; $display("FAIL rand_tiles #%0d: tile set %b want 00011011", i, seen); end
      if (board === SOLVED) begin errors++; $display("FAIL rand_unsolved #%0d: got solved %b", i, board); end
      if (lat < 19 || lat > 26) begin errors++; $display("FAIL rand_range #%0d: latency %0d want 19..26", i, lat); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, elat, pulses;
    logic [11:0] eb;
    idle_all();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(ml, 16, eb, elat);
      wait_valid(2, 1'b0, lat);
      checks += 2;
      if (lat !== elat) begin errors++; $display("FAIL held_latency #%0d: got %0d want %0d", k, lat, elat); end
      if (board !== eb) begin errors++; $display("FAIL held_board #%0d: got %b want %b", k, board, eb); end
    end
    start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_d);
      if (valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL held_release: %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_busy_start;
    int lat, elat, pulses;
    logic [11:0] eb, got;
    idle_all();
    start = 1'b1;
    model(ml, 16, eb, elat);
    pulses = 0;
    lat = -1;
    got = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_d);
      if (valid) begin
        pulses++;
        if (lat < 0) begin lat = c; got = board; end
      end
      start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    checks += 3;
    if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    if (lat !== elat) begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, elat); end
    if (got !== eb) begin errors++; $display("FAIL busy_board: got %b want %b", got, eb); end
  endtask

  task automatic test_reset_mid;
    int lat, elat;
    logic [11:0] eb;
    idle_all();
    start = 1'b1;
    @(negedge clk_d);
    start = 1'b0;
    repeat (5) @(negedge clk_d);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1 before reset", busy); end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", valid); end
    if (board !== SOLVED) begin errors++; $display("FAIL mid_reset_board: got %b want %b", board, SOLVED); end
    @(negedge clk_d);
    reset = 1'b0;
    repeat (3) @(negedge clk_d);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_idle: busy %b want 0", busy); end
    start = 1'b1;
    model(ml, 16, eb, elat);
    wait_valid(2, 1'b1, lat);
    checks += 2;
    if (lat !== elat) begin errors++; $display("FAIL mid_after_latency: got %0d want %0d", lat, elat); end
    if (board !== eb) begin errors++; $display("FAIL mid_after_board: got %b want %b", board, eb); end
  endtask

  initial begin
    test_reset();
    test_zero_steps();
    test_one_step(1'b1);
    test_one_step(1'b0);
    test_random(1000);
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
